// File: rtl/alu_arbiter_pkg.sv
// Shared types and sizes for the four-requester ALU arbiter.
package alu_arb_pkg;
  localparam int NREQ = 4;
  localparam int IDXW = 2;
  localparam int CNTW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GRANT = 2'b01,
    BUSY  = 2'b10
  } state_t;
endpackage

// File: rtl/alu_arbiter_decoder.sv
// Index to one-hot decoder; output is all-zero when i_en is low.
module decoder_block
  import alu_arb_pkg::*;
(
  input  logic [IDXW-1:0] i_idx,
  input  logic            i_en,
  output logic [NREQ-1:0] o_onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_dec
      assign o_onehot[gi] = i_en && (i_idx == IDXW'(gi));
    end
  endgenerate

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin owner selection for a shared ALU: grant, one-cycle start,
// wait for completion or timeout, then a done/err pulse back to the owner.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int OPW     = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*OPW-1:0] req_op,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     done,
  output logic [NREQ-1:0]     err,
  output logic                busy,
  output logic                alu_start,
  output logic [OPW-1:0]      alu_op,
  input  logic                alu_done
);

  state_t            r_state;
  state_t            w_state_next;
  logic [IDXW-1:0]   r_ptr;
  logic [IDXW-1:0]   w_ptr_next;
  logic [IDXW-1:0]   r_owner;
  logic [IDXW-1:0]   w_owner_next;
  logic [CNTW-1:0]   r_cnt;
  logic [CNTW-1:0]   w_cnt_next;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   w_gnt_next;
  logic [NREQ-1:0]   r_done;
  logic [NREQ-1:0]   w_done_next;
  logic [NREQ-1:0]   r_err;
  logic [NREQ-1:0]   w_err_next;
  logic              r_busy;
  logic              w_busy_next;
  logic              r_start;
  logic              w_start_next;
  logic [OPW-1:0]    r_alu_op;
  logic [OPW-1:0]    w_alu_op_next;

  logic [NREQ-1:0]   w_elig;
  logic              w_any;
  logic [IDXW-1:0]   w_sel;
  logic [NREQ-1:0]   w_sel_oh;
  logic [NREQ-1:0]   w_own_oh;

  // A requester being told done/err this cycle must not win again immediately.
  assign w_elig = req & ~(r_done | r_err);
  assign w_any  = |w_elig;

  // Walk downward so the candidate closest to r_ptr is written last and wins.
  always_comb begin
    w_sel = r_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_elig[r_ptr + IDXW'(i)]) begin
        w_sel = r_ptr + IDXW'(i);
      end
    end
  end

  decoder_block u_dec_sel (
    .i_idx    (w_sel),
    .i_en     (w_any && (r_state == IDLE)),
    .o_onehot (w_sel_oh)
  );

  decoder_block u_dec_own (
    .i_idx    (r_owner),
    .i_en     (r_state != IDLE),
    .o_onehot (w_own_oh)
  );

  always_comb begin
    w_state_next  = r_state;
    w_ptr_next    = r_ptr;
    w_owner_next  = r_owner;
    w_cnt_next    = r_cnt;
    w_gnt_next    = '0;
    w_done_next   = '0;
    w_err_next    = '0;
    w_busy_next   = 1'b0;
    w_start_next  = 1'b0;
    w_alu_op_next = r_alu_op;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (w_any) begin
          w_state_next  = GRANT;
          w_owner_next  = w_sel;
          w_alu_op_next = req_op[int'(w_sel) * OPW +: OPW];
          w_gnt_next    = w_sel_oh;
          w_start_next  = 1'b1;
          w_busy_next   = 1'b1;
        end
      end
      GRANT: begin
        w_state_next = BUSY;
        w_gnt_next   = w_own_oh;
        w_busy_next  = 1'b1;
        w_cnt_next   = CNTW'(1);
      end
      BUSY: begin
        // Completion is checked first so a done coinciding with timeout wins.
        if (alu_done) begin
          w_state_next = IDLE;
          w_done_next  = w_own_oh;
          w_ptr_next   = r_owner + IDXW'(1);
          w_cnt_next   = '0;
        end else if (r_cnt == CNTW'(TIMEOUT)) begin
          w_state_next = IDLE;
          w_err_next   = w_own_oh;
          w_ptr_next   = r_owner + IDXW'(1);
          w_cnt_next   = '0;
        end else begin
          w_gnt_next   = w_own_oh;
          w_busy_next  = 1'b1;
          w_cnt_next   = r_cnt + CNTW'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_cnt    <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_err    <= '0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
      r_alu_op <= '0;
    end else begin
      r_state  <= w_state_next;
      r_ptr    <= w_ptr_next;
      r_owner  <= w_owner_next;
      r_cnt    <= w_cnt_next;
      r_gnt    <= w_gnt_next;
      r_done   <= w_done_next;
      r_err    <= w_err_next;
      r_busy   <= w_busy_next;
      r_start  <= w_start_next;
      r_alu_op <= w_alu_op_next;
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign err       = r_err;
  assign busy      = r_busy;
  assign alu_start = r_start;
  assign alu_op    = r_alu_op;

endmodule
